// File: rtl/traffic_light_timed.sv
// Two-road intersection controller: timed main/side phases, latched side request, all-red clearance, flash mode.
// Latency: lamps and phase decode combinationally from the state register; side_req reaches req_pending in 1 cycle.
// Backpressure: none; side_req and flash are sampled every cycle and never stalled.
module traffic_light_timed #(
    parameter int CNT_W        = 8,
    parameter int GREEN_T      = 20,
    parameter int SIDE_GREEN_T = 10,
    parameter int YELLOW_T     = 4,
    parameter int ALLRED_T     = 2,
    parameter int FLASH_T      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_req,
    input  logic       flash,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic [2:0] phase,
    output logic       req_pending
);

    // Encodings are visible on the phase port, so they are fixed explicitly.
    typedef enum logic [2:0] {
        S_MG  = 3'd0,
        S_MY  = 3'd1,
        S_AR1 = 3'd2,
        S_SG  = 3'd3,
        S_SY  = 3'd4,
        S_AR2 = 3'd5,
        S_FL  = 3'd6
    } state_e;

    // Timer reload values: a state lasts (load + 1) cycles because it ends when the timer reads 0.
    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] LD_SIDE   = CNT_W'(SIDE_GREEN_T - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(FLASH_T - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             blink_q, blink_d;
    logic             pend_q,  pend_d;

    logic             timer_done;
    logic [CNT_W-1:0] timer_dec;
    logic             enter_serve;

    assign timer_done = (timer_q == '0);
    assign timer_dec  = timer_q - CNT_W'(1);

    // State, timer, blink and request registers; reset parks in all-red clearance before main green.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_AR2;
            timer_q <= LD_ALLRED;
            blink_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state and timer: flash overrides everything; main green waits at timer 0 for a request.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        blink_d = blink_q;
        if (flash && (state_q != S_FL)) begin
            state_d = S_FL;
            timer_d = LD_FLASH;
            blink_d = 1'b1;
        end else begin
            case (state_q)
                S_MG: begin
                    if (timer_done) begin
                        if (pend_q) begin
                            state_d = S_MY;
                            timer_d = LD_YELLOW;
                        end
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                S_MY: begin
                    if (timer_done) begin
                        state_d = S_AR1;
                        timer_d = LD_ALLRED;
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                S_AR1: begin
                    if (timer_done) begin
                        state_d = S_SG;
                        timer_d = LD_SIDE;
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                S_SG: begin
                    if (timer_done) begin
                        state_d = S_SY;
                        timer_d = LD_YELLOW;
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                S_SY: begin
                    if (timer_done) begin
                        state_d = S_AR2;
                        timer_d = LD_ALLRED;
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                S_AR2: begin
                    if (timer_done) begin
                        state_d = S_MG;
                        timer_d = LD_GREEN;
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                S_FL: begin
                    // Leaving flash always passes through all-red so no green follows a blink directly.
                    if (!flash) begin
                        state_d = S_AR2;
                        timer_d = LD_ALLRED;
                    end else if (timer_done) begin
                        timer_d = LD_FLASH;
                        blink_d = ~blink_q;
                    end else begin
                        timer_d = timer_dec;
                    end
                end
                default: begin
                    state_d = S_AR2;
                    timer_d = LD_ALLRED;
                end
            endcase
        end
    end

    // Side request latch: entering side green (served) or flash (abandoned) clears it, and that clear wins.
    always_comb begin
        pend_d      = pend_q;
        enter_serve = ((state_d == S_SG) && (state_q != S_SG)) ||
                      ((state_d == S_FL) && (state_q != S_FL));
        if (enter_serve) begin
            pend_d = 1'b0;
        end else if (side_req && (state_q != S_SG) && (state_q != S_FL)) begin
            pend_d = 1'b1;
        end
    end

    // Lamp decode: one lamp per road except in flash; unknown encodings show all red.
    always_comb begin
        main_red    = 1'b0;
        main_yellow = 1'b0;
        main_green  = 1'b0;
        side_red    = 1'b0;
        side_yellow = 1'b0;
        side_green  = 1'b0;
        case (state_q)
            S_MG: begin
                main_green = 1'b1;
                side_red   = 1'b1;
            end
            S_MY: begin
                main_yellow = 1'b1;
                side_red    = 1'b1;
            end
            S_SG: begin
                main_red   = 1'b1;
                side_green = 1'b1;
            end
            S_SY: begin
                main_red    = 1'b1;
                side_yellow = 1'b1;
            end
            S_FL: begin
                main_yellow = blink_q;
                side_red    = 1'b1;
            end
            default: begin
                main_red = 1'b1;
                side_red = 1'b1;
            end
        endcase
    end

    assign phase       = state_q;
    assign req_pending = pend_q;

endmodule
